// File: rtl/seven_seg_pkg.sv
// Shared types, glyph constants and width helper for the seven-segment scan driver.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    // Active-low abcdefg, bit6 = a, bit0 = g
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b1100000;
    localparam seg_t SEG_C     = 7'b0110001;
    localparam seg_t SEG_D     = 7'b1000010;
    localparam seg_t SEG_E     = 7'b0110000;
    localparam seg_t SEG_F     = 7'b0111000;

    // Counter width for a 0..n-1 range, never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seven_seg_glyph.sv
// Combinational 4-bit code to active-low segment pattern decoder.
module seven_seg_glyph
    import seven_seg_pkg::*;
#(
    parameter bit HEX_EN = 1'b0
) (
    input  logic [3:0] code,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (code)
            4'd0:  seg_c = SEG_0;
            4'd1:  seg_c = SEG_1;
            4'd2:  seg_c = SEG_2;
            4'd3:  seg_c = SEG_3;
            4'd4:  seg_c = SEG_4;
            4'd5:  seg_c = SEG_5;
            4'd6:  seg_c = SEG_6;
            4'd7:  seg_c = SEG_7;
            4'd8:  seg_c = SEG_8;
            4'd9:  seg_c = SEG_9;
            4'd10: seg_c = HEX_EN ? SEG_A : SEG_BLANK;
            4'd11: seg_c = HEX_EN ? SEG_B : SEG_BLANK;
            4'd12: seg_c = HEX_EN ? SEG_C : SEG_BLANK;
            4'd13: seg_c = HEX_EN ? SEG_D : SEG_BLANK;
            4'd14: seg_c = HEX_EN ? SEG_E : SEG_BLANK;
            4'd15: seg_c = HEX_EN ? SEG_F : SEG_BLANK;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with shadowed digit data,
// leading-zero suppression, blanking, blinking and decimal points.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 3,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter bit          HEX_EN       = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    input  logic [N_DIGITS-1:0]     blink_in,
    input  logic                    lzs_en,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [N_DIGITS-1:0]     an_n,
    output logic                    frame_tick
);

    localparam int unsigned PW = cnt_w(REFRESH_DIV);
    localparam int unsigned FW = cnt_w(BLINK_FRAMES);
    localparam int unsigned IW = cnt_w(N_DIGITS);
    localparam int unsigned DW = 4 * N_DIGITS;
    localparam logic [N_DIGITS-1:0] AN_ONE = N_DIGITS'(1);

    logic [DW-1:0]       sh_digits;
    logic [N_DIGITS-1:0] sh_dp;
    logic [N_DIGITS-1:0] sh_blank;
    logic [N_DIGITS-1:0] sh_blink;
    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic [FW-1:0]       frame_cnt;
    logic                blink_phase;

    logic                presc_wrap_c;
    logic                idx_last_c;
    logic                frame_wrap_c;
    logic [N_DIGITS-1:0] lead_zero_c;
    logic                zero_run_c;
    logic [3:0]          code_c;
    logic                dp_c;
    logic                dark_c;
    logic [6:0]          glyph_c;

    assign presc_wrap_c = (presc == PW'(REFRESH_DIV - 1));
    assign idx_last_c   = (idx == IW'(N_DIGITS - 1));
    assign frame_wrap_c = (frame_cnt == FW'(BLINK_FRAMES - 1));

    // lead_zero_c[i]: digits N_DIGITS-1 down to i are all code 0
    always_comb begin
        lead_zero_c = '0;
        zero_run_c  = 1'b1;
        for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
            zero_run_c     = zero_run_c && (sh_digits[4*i +: 4] == 4'd0);
            lead_zero_c[i] = zero_run_c;
        end
    end

    // Select the scanned digit and decide whether it is dark
    always_comb begin
        code_c = 4'd0;
        dp_c   = 1'b0;
        dark_c = 1'b0;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (idx == IW'(i)) begin
                code_c = sh_digits[4*i +: 4];
                dp_c   = sh_dp[i];
                dark_c = sh_blank[i]
                       | (sh_blink[i] & blink_phase)
                       | (lzs_en & (i != 0) & lead_zero_c[i]);
            end
        end
    end

    seven_seg_glyph #(
        .HEX_EN (HEX_EN)
    ) u_glyph (
        .code  (code_c),
        .seg_c (glyph_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_digits   <= '0;
            sh_dp       <= '0;
            sh_blank    <= '0;
            sh_blink    <= '0;
            presc       <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            seg_n       <= SEG_BLANK;
            dp_n        <= 1'b1;
            an_n        <= '1;
            frame_tick  <= 1'b0;
        end else begin
            if (load) begin
                sh_digits <= digits_in;
                sh_dp     <= dp_in;
                sh_blank  <= blank_in;
                sh_blink  <= blink_in;
            end

            presc <= presc_wrap_c ? '0 : presc + PW'(1);
            if (presc_wrap_c) begin
                idx <= idx_last_c ? '0 : idx + IW'(1);
            end

            if (presc_wrap_c && idx_last_c) begin
                if (frame_wrap_c) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
            frame_tick <= presc_wrap_c && idx_last_c;

            // Anodes stay off for count 0 of each slot so the previous digit cannot ghost
            an_n  <= (presc == '0) ? '1 : ~(AN_ONE << idx);
            seg_n <= dark_c ? SEG_BLANK : glyph_c;
            dp_n  <= dark_c | ~dp_c;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed self-checking bench for seven_seg_scan_driver (3 digits, 4-cycle slots, 2-frame blink).
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic        lzs_en;
    logic [11:0] digits_in;
    logic [2:0]  dp_in;
    logic [2:0]  blank_in;
    logic [2:0]  blink_in;

    logic [6:0]  seg_n;
    logic        dp_n;
    logic [2:0]  an_n;
    logic        frame_tick;
    logic [6:0]  seg_n_hex;
    logic        dp_n_hex;
    logic [2:0]  an_n_hex;
    logic        frame_tick_hex;

    int checks = 0;
    int fails  = 0;
    int k      = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .N_DIGITS (3), .REFRESH_DIV (4), .BLINK_FRAMES (2), .HEX_EN (1'b0)
    ) dut (
        .clk (clk), .reset (reset), .digits_in (digits_in), .load (load),
        .dp_in (dp_in), .blank_in (blank_in), .blink_in (blink_in), .lzs_en (lzs_en),
        .seg_n (seg_n), .dp_n (dp_n), .an_n (an_n), .frame_tick (frame_tick)
    );

    seven_seg_scan_driver #(
        .N_DIGITS (3), .REFRESH_DIV (4), .BLINK_FRAMES (2), .HEX_EN (1'b1)
    ) dut_hex (
        .clk (clk), .reset (reset), .digits_in (digits_in), .load (load),
        .dp_in (dp_in), .blank_in (blank_in), .blink_in (blink_in), .lzs_en (lzs_en),
        .seg_n (seg_n_hex), .dp_n (dp_n_hex), .an_n (an_n_hex), .frame_tick (frame_tick_hex)
    );

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int t);
        while (k < t) step();
    endtask

    // One reset cycle, then load on the first free edge; k = 0 just after that edge
    task automatic restart(input logic [11:0] d, input logic [2:0] dp, input logic [2:0] bl,
                           input logic [2:0] bk, input logic lz);
        reset = 1'b1;
        load  = 1'b0;
        step();
        reset     = 1'b0;
        load      = 1'b1;
        digits_in = d;
        dp_in     = dp;
        blank_in  = bl;
        blink_in  = bk;
        lzs_en    = lz;
        step();
        load = 1'b0;
        k    = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b1; digits_in = 12'h543; dp_in = 3'b111;
        blank_in = 3'b000; blink_in = 3'b000; lzs_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (seg_n !== 7'b1111111) begin fails++; $display("FAIL reset_seg cyc%0d: got %b expected 1111111", c, seg_n); end
            checks++; if (dp_n !== 1'b1) begin fails++; $display("FAIL reset_dp cyc%0d: got %b expected 1", c, dp_n); end
            checks++; if (an_n !== 3'b111) begin fails++; $display("FAIL reset_an cyc%0d: got %b expected 111", c, an_n); end
            checks++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_tick cyc%0d: got %b expected 0", c, frame_tick); end
        end
        reset = 1'b0; load = 1'b0;
        step();
        k = 0;
        checks++; if (an_n !== 3'b111) begin fails++; $display("FAIL reset_rel_an: got %b expected 111", an_n); end
        run_to(2);
        checks++; if (an_n !== 3'b110 || seg_n !== 7'b0000001 || dp_n !== 1'b1) begin fails++; $display("FAIL reset_shadow_d0: got an %b seg %b dp %b expected 110 0000001 1", an_n, seg_n, dp_n); end
        run_to(6);
        checks++; if (an_n !== 3'b101 || seg_n !== 7'b0000001) begin fails++; $display("FAIL reset_shadow_d1: got an %b seg %b expected 101 0000001", an_n, seg_n); end
        run_to(10);
        checks++; if (an_n !== 3'b011 || seg_n !== 7'b0000001) begin fails++; $display("FAIL reset_shadow_d2: got an %b seg %b expected 011 0000001", an_n, seg_n); end
    endtask

    task automatic test_scan();
        logic [2:0] exp_an;
        logic [6:0] exp_seg;
        restart(12'h543, 3'b000, 3'b000, 3'b000, 1'b0);
        for (int t = 1; t <= 24; t++) begin
            run_to(t);
            case ((t / 4) % 3)
                0:       begin exp_an = 3'b110; exp_seg = 7'b0000110; end
                1:       begin exp_an = 3'b101; exp_seg = 7'b1001100; end
                default: begin exp_an = 3'b011; exp_seg = 7'b0100100; end
            endcase
            if (t % 4 == 0) exp_an = 3'b111;
            checks++; if (an_n !== exp_an) begin fails++; $display("FAIL scan_an t%0d: got %b expected %b", t, an_n, exp_an); end
            if (t % 4 != 0) begin
                checks++; if (seg_n !== exp_seg) begin fails++; $display("FAIL scan_seg t%0d: got %b expected %b", t, seg_n, exp_seg); end
            end
            checks++; if (frame_tick !== (t % 12 == 11)) begin fails++; $display("FAIL scan_tick t%0d: got %b expected %b", t, frame_tick, (t % 12 == 11)); end
        end
    endtask

    task automatic test_lzs();
        restart(12'h000, 3'b000, 3'b000, 3'b000, 1'b1);
        run_to(2);
        checks++; if (seg_n !== 7'b0000001) begin fails++; $display("FAIL lzs000_d0: got %b expected 0000001", seg_n); end
        run_to(6);
        checks++; if (seg_n !== 7'b1111111 || an_n !== 3'b101) begin fails++; $display("FAIL lzs000_d1: got seg %b an %b expected 1111111 101", seg_n, an_n); end
        run_to(10);
        checks++; if (seg_n !== 7'b1111111 || an_n !== 3'b011) begin fails++; $display("FAIL lzs000_d2: got seg %b an %b expected 1111111 011", seg_n, an_n); end
        restart(12'h070, 3'b000, 3'b000, 3'b000, 1'b1);
        run_to(2);
        checks++; if (seg_n !== 7'b0000001) begin fails++; $display("FAIL lzs070_d0: got %b expected 0000001", seg_n); end
        run_to(6);
        checks++; if (seg_n !== 7'b0001111) begin fails++; $display("FAIL lzs070_d1: got %b expected 0001111", seg_n); end
        run_to(10);
        checks++; if (seg_n !== 7'b1111111) begin fails++; $display("FAIL lzs070_d2: got %b expected 1111111", seg_n); end
        restart(12'h000, 3'b000, 3'b000, 3'b000, 1'b0);
        run_to(10);
        checks++; if (seg_n !== 7'b0000001) begin fails++; $display("FAIL lzs_off_d2: got %b expected 0000001", seg_n); end
    endtask

    task automatic test_blink_dp();
        logic lit;
        restart(12'h008, 3'b001, 3'b000, 3'b001, 1'b0);
        for (int f = 0; f < 6; f++) begin
            run_to(12 * f + 2);
            lit = ((f % 4) < 2);
            checks++; if (seg_n !== (lit ? 7'b0000000 : 7'b1111111) || an_n !== 3'b110) begin fails++; $display("FAIL blink_seg f%0d: got seg %b an %b expected lit=%b an 110", f, seg_n, an_n, lit); end
            checks++; if (dp_n !== ~lit) begin fails++; $display("FAIL blink_dp f%0d: got %b expected %b", f, dp_n, ~lit); end
        end
    endtask

    task automatic test_hex_blank();
        restart(12'h0FA, 3'b000, 3'b000, 3'b000, 1'b0);
        run_to(2);
        checks++; if (seg_n !== 7'b1111111) begin fails++; $display("FAIL hex_off_A: got %b expected 1111111", seg_n); end
        checks++; if (seg_n_hex !== 7'b0001000) begin fails++; $display("FAIL hex_on_A: got %b expected 0001000", seg_n_hex); end
        run_to(6);
        checks++; if (seg_n !== 7'b1111111) begin fails++; $display("FAIL hex_off_F: got %b expected 1111111", seg_n); end
        checks++; if (seg_n_hex !== 7'b0111000) begin fails++; $display("FAIL hex_on_F: got %b expected 0111000", seg_n_hex); end
        restart(12'h008, 3'b001, 3'b001, 3'b000, 1'b0);
        run_to(2);
        checks++; if (seg_n !== 7'b1111111 || dp_n !== 1'b1 || an_n !== 3'b110) begin fails++; $display("FAIL blank_d0: got seg %b dp %b an %b expected 1111111 1 110", seg_n, dp_n, an_n); end
        checks++; if (seg_n_hex !== 7'b1111111) begin fails++; $display("FAIL blank_d0_hex: got %b expected 1111111", seg_n_hex); end
    endtask

    task automatic test_back_to_back();
        restart(12'h543, 3'b000, 3'b000, 3'b000, 1'b0);
        run_to(2);
        load = 1'b1; digits_in = 12'h111;
        step();
        load = 1'b0;
        checks++; if (seg_n !== 7'b0000110) begin fails++; $display("FAIL reload_latency: got %b expected 0000110", seg_n); end
        run_to(5);
        checks++; if (seg_n !== 7'b1001111 || an_n !== 3'b101) begin fails++; $display("FAIL reload_d1: got seg %b an %b expected 1001111 101", seg_n, an_n); end
    endtask

    task automatic test_reset_mid();
        restart(12'h543, 3'b000, 3'b000, 3'b000, 1'b0);
        run_to(6);
        checks++; if (an_n !== 3'b101) begin fails++; $display("FAIL mid_pre_an: got %b expected 101", an_n); end
        reset = 1'b1;
        step();
        checks++; if (seg_n !== 7'b1111111 || dp_n !== 1'b1 || an_n !== 3'b111 || frame_tick !== 1'b0) begin fails++; $display("FAIL mid_reset: got seg %b dp %b an %b tick %b expected 1111111 1 111 0", seg_n, dp_n, an_n, frame_tick); end
        reset = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        k = 0;
        checks++; if (an_n !== 3'b111) begin fails++; $display("FAIL mid_rel_an: got %b expected 111", an_n); end
        run_to(1);
        checks++; if (an_n !== 3'b110 || seg_n !== 7'b0000110) begin fails++; $display("FAIL mid_first_slot: got an %b seg %b expected 110 0000110", an_n, seg_n); end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; lzs_en = 1'b0; digits_in = '0;
        dp_in = '0; blank_in = '0; blink_in = '0;
        test_reset();
        test_scan();
        test_lzs();
        test_blink_dp();
        test_hex_blank();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
